// File: rtl/cla_pkg.sv
// Shared definitions for the multi-word sequential adder wrapper.
//   WORD_W      : width of one word handled by the external adder stage
//   DEF_NWORDS  : default number of words per operand
//   DEF_ADD_LAT : default latency of the registered adder stage
//   state_t     : sequencer state encoding
package cla_pkg;

    localparam int WORD_W      = 32;
    localparam int DEF_NWORDS  = 4;
    localparam int DEF_ADD_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_mw_seq.sv
// Word-serial wide adder sequencer. Splits a W = 32*NWORDS bit addition into
// NWORDS 32-bit additions issued one at a time to an external registered
// adder stage, chaining the carry from each word into the next.
//
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (a, b, ci)
//   add_a, add_b, add_ci  : registered word issued to the adder stage
//   add_s, add_co         : registered sum/carry returned by the adder stage
//   out_valid / out_ready : result handshake (s, co)
module cla_mw_seq
    import cla_pkg::*;
#(
    parameter int NWORDS  = DEF_NWORDS,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NWORDS*WORD_W-1:0] a,
    input  logic [NWORDS*WORD_W-1:0] b,
    input  logic                     ci,
    output logic [WORD_W-1:0]        add_a,
    output logic [WORD_W-1:0]        add_b,
    output logic                     add_ci,
    input  logic [WORD_W-1:0]        add_s,
    input  logic                     add_co,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NWORDS*WORD_W-1:0] s,
    output logic                     co
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int CNT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT);

    state_t                        state;
    logic [NWORDS-1:0][WORD_W-1:0] a_w, b_w;
    logic [NWORDS-1:0][WORD_W-1:0] a_q, b_q, s_q;
    logic [IDX_W-1:0]              idx, idx_nxt;
    logic [CNT_W-1:0]              cnt;

    assign a_w     = a;
    assign b_w     = b;
    assign s       = s_q;
    assign idx_nxt = idx + IDX_W'(1);

    // The counter is loaded with ADD_LAT on every issue edge and the word is
    // captured on the edge where it is already zero, giving ADD_LAT+1 edges
    // between issue and capture. A reset leaves stale words in the adder
    // pipeline; they drain before the reloaded counter expires.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s_q       <= '0;
            co        <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_ci    <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a_w;
                        b_q      <= b_w;
                        add_a    <= a_w[0];
                        add_b    <= b_w[0];
                        add_ci   <= ci;
                        idx      <= '0;
                        cnt      <= CNT_LOAD;
                        in_ready <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        s_q[idx] <= add_s;
                        if (idx == LAST_IDX) begin
                            co        <= add_co;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            // carry of word i becomes carry-in of word i+1
                            add_a  <= a_q[idx_nxt];
                            add_b  <= b_q[idx_nxt];
                            add_ci <= add_co;
                            idx    <= idx_nxt;
                            cnt    <= CNT_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    // in_ready rises only after this edge, so an in_valid
                    // coinciding with out_ready is taken no earlier than next edge
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_mw_seq.sv
// Directed bench for cla_mw_seq with a behavioural 2-deep registered adder.
module tb_cla_mw_seq;

    localparam int NW     = 4;
    localparam int LAT    = 2;
    localparam int W      = 32 * NW;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic          ci;
    logic [31:0]   add_a, add_b, add_s;
    logic          add_ci, add_co;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          co;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cla_mw_seq #(.NWORDS(NW), .ADD_LAT(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .add_co    (add_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
    );

    // registered adder stage: samples inputs, result valid LAT edges later
    logic [32:0] pipe [LAT];
    always @(posedge clock) begin
        pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign add_s  = pipe[LAT-1][31:0];
    assign add_co = pipe[LAT-1][32];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a = av; b = bv; ci = cv; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic run_to_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0;
        tick; tick;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (s !== '0) begin failures++; $display("FAIL reset_s got=%h exp=0", s); end
        checks++; if (co !== 1'b0) begin failures++; $display("FAIL reset_co got=%b exp=0", co); end
        checks++; if (add_a !== 32'd0 || add_b !== 32'd0 || add_ci !== 1'b0) begin
            failures++; $display("FAIL reset_add got=%h/%h/%b exp=0/0/0", add_a, add_b, add_ci);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int n;
        accept(128'h00000001_00000002_00000003_00000004, 128'h10000000_20000000_30000000_40000000, 1'b0);
        a = '1; b = '1;  // operands may change after acceptance
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready got=%b exp=0", in_ready); end
        checks++; if (add_a !== 32'h4 || add_b !== 32'h40000000 || add_ci !== 1'b0) begin
            failures++; $display("FAIL basic_issue0 got=%h/%h/%b exp=00000004/40000000/0", add_a, add_b, add_ci);
        end
        run_to_done(n);
        checks++; if (n != 12) begin failures++; $display("FAIL basic_latency got=%0d exp=12", n); end
        checks++; if (s !== 128'h10000001_20000002_30000003_40000004) begin
            failures++; $display("FAIL basic_sum got=%h exp=10000001200000023000000340000004", s);
        end
        checks++; if (co !== 1'b0) begin failures++; $display("FAIL basic_co got=%b exp=0", co); end
        release_result;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL basic_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry_chain;
        accept('1, '0, 1'b1);
        checks++; if (add_ci !== 1'b1) begin failures++; $display("FAIL carry_issue0 got=%b exp=1", add_ci); end
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == 3 || k == 6 || k == 9) begin
                checks++;
                if (add_ci !== 1'b1 || add_a !== 32'hFFFFFFFF) begin
                    failures++; $display("FAIL carry_issue_edge%0d got ci=%b a=%h exp ci=1 a=ffffffff", k, add_ci, add_a);
                end
            end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL carry_valid got=%b exp=1", out_valid); end
        checks++; if (s !== '0 || co !== 1'b1) begin failures++; $display("FAIL carry_result got=%h/%b exp=0/1", s, co); end
        release_result;
    endtask

    task automatic test_boundary;
        int n;
        accept('1, '1, 1'b1);
        run_to_done(n);
        checks++; if (n != 12 || s !== {W{1'b1}} || co !== 1'b1) begin
            failures++; $display("FAIL boundary_ones got n=%0d s=%h co=%b exp n=12 s=all-ones co=1", n, s, co);
        end
        release_result;
    endtask

    task automatic test_hold;
        int n;
        accept(128'h5, 128'h7, 1'b0);
        run_to_done(n);
        a = 128'h10; b = 128'h20; in_valid = 1'b1;  // ignored while DONE
        for (int k = 0; k < 5; k++) begin
            tick;
            checks++;
            if (out_valid !== 1'b1 || s !== 128'hC || co !== 1'b0 || in_ready !== 1'b0) begin
                failures++; $display("FAIL hold_cycle%0d got ov=%b s=%h co=%b ir=%b exp ov=1 s=c co=0 ir=0", k, out_valid, s, co, in_ready);
            end
        end
        a = 128'h100; b = 128'h200; out_ready = 1'b1;
        tick;  // result taken; coincident in_valid not accepted
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL hold_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
        end
        tick;  // accepted here
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || add_a !== 32'h100) begin
            failures++; $display("FAIL hold_next_accept got ir=%b add_a=%h exp ir=0 add_a=00000100", in_ready, add_a);
        end
        run_to_done(n);
        checks++; if (n != 12 || s !== 128'h300 || co !== 1'b0) begin
            failures++; $display("FAIL hold_next_result got n=%0d s=%h co=%b exp n=12 s=300 co=0", n, s, co);
        end
        release_result;
    endtask

    task automatic test_reset_mid;
        int n;
        accept('1, '1, 1'b1);
        repeat (6) tick;
        reset = 1'b1;
        tick;  // edge S+7
        reset = 1'b0;
        checks++; if (s !== '0 || co !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL midreset_out got s=%h co=%b ov=%b exp 0/0/0", s, co, out_valid);
        end
        checks++; if (add_a !== 32'd0 || add_b !== 32'd0 || add_ci !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_add got %h/%h/%b ir=%b exp 0/0/0 ir=1", add_a, add_b, add_ci, in_ready);
        end
        accept(128'h1, 128'h1, 1'b0);
        run_to_done(n);
        checks++; if (n != 12 || s !== 128'h2 || co !== 1'b0) begin
            failures++; $display("FAIL midreset_next got n=%0d s=%h co=%b exp n=12 s=2 co=0", n, s, co);
        end
        release_result;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] va [3], vb [3], vs [3];
        logic         vc [3], vco [3];
        int           acc_t [3], res_t [3];
        int           na, nr;
        logic         ir, ov, cc;
        logic [W-1:0] so;
        va[0] = 128'h1;          vb[0] = 128'h2; vc[0] = 1'b0; vs[0] = 128'h3;           vco[0] = 1'b0;
        va[1] = 128'hFFFFFFFF;   vb[1] = 128'h1; vc[1] = 1'b0; vs[1] = 128'h1_00000000;  vco[1] = 1'b0;
        va[2] = {1'b1, 127'd0};  vb[2] = {1'b1, 127'd0}; vc[2] = 1'b1; vs[2] = 128'h1;   vco[2] = 1'b1;
        na = 0; nr = 0;
        for (int i = 0; i < 3; i++) begin acc_t[i] = -1; res_t[i] = -1; end
        out_ready = 1'b1;
        a = va[0]; b = vb[0]; ci = vc[0]; in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            ir = in_ready; ov = out_valid; so = s; cc = co;
            tick;
            if (ir && in_valid) begin
                if (na < 3) acc_t[na] = t;
                na++;
                if (na < 3) begin a = va[na]; b = vb[na]; ci = vc[na]; end
                else in_valid = 1'b0;
            end
            if (ov) begin
                checks++;
                if (nr >= 3) begin
                    failures++; $display("FAIL b2b_extra_result got=%0d exp<=3", nr + 1);
                end else if (so !== vs[nr] || cc !== vco[nr]) begin
                    failures++; $display("FAIL b2b_result%0d got s=%h co=%b exp s=%h co=%b", nr, so, cc, vs[nr], vco[nr]);
                end
                if (nr < 3) res_t[nr] = t;
                nr++;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (na != 3 || nr != 3) begin failures++; $display("FAIL b2b_counts got acc=%0d res=%0d exp 3/3", na, nr); end
        checks++; if (res_t[0] - acc_t[0] != 13) begin
            failures++; $display("FAIL b2b_first_latency got=%0d exp=13", res_t[0] - acc_t[0]);
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (res_t[i] - res_t[i-1] != 14) begin
                failures++; $display("FAIL b2b_period%0d got=%0d exp=14", i, res_t[i] - res_t[i-1]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry_chain;
        test_boundary;
        test_hold;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_mw_seq.md
CLA_MW_SEQ -- requirements
Module: cla_mw_seq

Interface
REQ-001 Parameter NWORDS, default 4, number of 32-bit words per operand; operand width W = 32*NWORDS.
REQ-002 Parameter ADD_LAT, default 2, clock edges from the adder stage sampling its inputs to its registered outputs becoming valid.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set a/b/ci is presented.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  W  first operand.
REQ-008 b  input  W  second operand.
REQ-009 ci  input  1  carry-in of the full-width addition.
REQ-010 add_a  output  32  word driven to the registered 32-bit adder stage.
REQ-011 add_b  output  32  word driven to the adder stage.
REQ-012 add_ci  output  1  carry driven to the adder stage.
REQ-013 add_s  input  32  registered sum returned by the adder stage.
REQ-014 add_co  input  1  registered carry returned by the adder stage.
REQ-015 out_valid  output  1  full-width result is available.
REQ-016 out_ready  input  1  consumer takes the result.
REQ-017 s  output  W  full-width sum.
REQ-018 co  output  1  carry out of the most significant word.

Function
REQ-019 Handshake: transfers occur only on edges where valid and ready are both high.
REQ-020 FSM states: IDLE, WAIT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-021 IDLE: on in_valid at edge S, latch a, b, ci; drive add_a/add_b from word 0 and add_ci from ci; clear word index; load wait counter; go to WAIT.
REQ-022 WAIT: add_* outputs are registered and stay stable until the next word is issued.
REQ-023 WAIT: the block captures add_s into s[32i+31:32i] on edge S+(ADD_LAT+1)(i+1), where i is the current word index.
REQ-024 At a capture edge for i < NWORDS-1: drive word i+1 on add_a/add_b, drive add_ci = add_co, increment the index, reload the counter.
REQ-025 At the capture edge for i = NWORDS-1: set co = add_co and go to DONE.
REQ-026 Latency: for defaults, the capture edges are S+3, S+6, S+9 and S+12; out_valid is high in the cycle after S+12.
REQ-027 DONE: s, co and out_valid are held stable until out_ready is high; then go to IDLE on that edge.
REQ-028 An in_valid that coincides with the out_ready edge is not accepted; it is accepted no earlier than the following edge.
REQ-029 in_valid is ignored in WAIT and DONE; a and b may change freely after acceptance.
REQ-030 Boundary: a = b = all-ones with ci = 1 gives s = all-ones and co = 1; the carry ripples through every word.
REQ-031 The block performs no arithmetic of its own; every sum bit and carry comes from the adder stage.

Reset
REQ-032 While reset is high at an edge, state becomes IDLE and s, co, add_a, add_b, add_ci and out_valid become 0; in_ready = 1 in the first cycle after reset.
REQ-033 Reset mid-operation aborts the addition; adder results still in flight are ignored, because the first accepted set after reset starts with a reloaded counter.
REQ-034 reset has priority over in_valid and out_ready.

Structure
REQ-035 Shared package cla_pkg holds: WORD_W = 32, the default NWORDS and ADD_LAT, and the FSM state enumeration.
REQ-036 No sub-module; the parent connects add_* to the registered 32-bit CLA adder stage.
REQ-037 Counter width is clog2(ADD_LAT+1); word index width is clog2(NWORDS), minimum 1.

Verification
REQ-038 The bench connects a behavioural model of the registered adder stage with ADD_LAT = 2.
REQ-039 a = 0x00000001_00000002_00000003_00000004, b = 0x10000000_20000000_30000000_40000000, ci = 0 -> s = 0x10000001_20000002_30000003_40000004, co = 0, out_valid in the cycle after S+12.
REQ-040 a = all-ones, b = 0, ci = 1 -> s = 0, co = 1; add_ci = 1 is observed at the issue of words 1, 2 and 3.
REQ-041 Result held with out_ready low for 5 cycles -> s, co and out_valid stay stable and in_ready stays 0; out_ready = 1 with in_valid = 1 -> the next set is accepted one edge later.
REQ-042 reset asserted at S+7 -> all outputs are 0 at the next edge; a new set 0x1 + 0x1 -> s = 0x2 with no corruption from the aborted operation.
REQ-043 Back-to-back operand sets with out_ready tied high -> one result per 14 cycles, in order, with no lost or duplicated transfers.
